div_unit: RTL and testbench

- Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the execute stage.
- Feeds the pipeline controller: it raises `pause_signal` while busy and pulses `unpause_signal` when it finishes.
- Result goes to writeback with its destination register tag.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_div_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the
//                execute stage. Radix-2 restoring division, one quotient bit
//                per cycle. Stalls the pipeline through o_pause_signal while
//                busy and pulses o_unpause_signal when it lets go.
//
//  Ports
//    clk              : clock, rising edge
//    rst              : asynchronous reset, active low
//    i_start          : issue a divide op (sampled only in IDLE)
//    i_op             : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//    i_dividend       : rs1 value
//    i_divisor        : rs2 value
//    i_rd_in          : destination register index
//    i_flush          : pipeline flush, aborts the in-flight op
//    o_pause_signal   : stall request (combinational)
//    o_unpause_signal : one-cycle release request
//    o_result         : quotient or remainder (registered)
//    o_result_valid   : one-cycle write enable for o_result
//    o_rd_out         : destination index paired with o_result
//
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic [4:0]      i_rd_in,
    input  logic            i_flush,
    output logic            o_pause_signal,
    output logic            o_unpause_signal,
    output logic [XLEN-1:0] o_result,
    output logic            o_result_valid,
    output logic [4:0]      o_rd_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_op_nxt;
    logic [4:0]        w_rd_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_div_nxt;
    logic              w_neg_q_nxt;
    logic              w_neg_r_nxt;
    logic              w_pause;
    logic              w_unpause;
    logic              w_valid;

    // ------------------------------------------------------------------
    // Issue-time operand conditioning. op[0]=1 means unsigned.
    // ------------------------------------------------------------------
    logic            w_signed;
    logic            w_dd_neg;
    logic            w_dv_neg;
    logic [XLEN-1:0] w_dd_abs;
    logic [XLEN-1:0] w_dv_abs;
    logic            w_div_zero;
    logic            w_ovf;

    assign w_signed   = ~i_op[0];
    assign w_dd_neg   = w_signed & i_dividend[XLEN-1];
    assign w_dv_neg   = w_signed & i_divisor[XLEN-1];
    assign w_dd_abs   = w_dd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign w_dv_abs   = w_dv_neg ? (~i_divisor + 1'b1) : i_divisor;
    assign w_div_zero = (i_divisor == '0);
    assign w_ovf      = w_signed && (i_dividend == c_MIN_NEG) && (i_divisor == '1);

    // ------------------------------------------------------------------
    // One restoring step. The shifted partial remainder can need XLEN+1
    // bits when the divisor is above 2**(XLEN-1); the borrow out of the
    // XLEN+1-bit subtract tells whether the trial fits.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic            w_fits;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;

    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_div};
    assign w_fits     = ~w_trial[XLEN];
    assign w_step_rem = w_fits ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_step_quo = {r_quo[XLEN-2:0], w_fits};

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_rd_nxt    = r_rd;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_div_nxt   = r_div;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_pause     = 1'b0;
        w_unpause   = 1'b0;
        w_valid     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_flush) begin
                    w_pause   = 1'b1;
                    w_op_nxt  = i_op;
                    w_rd_nxt  = i_rd_in;
                    w_cnt_nxt = '0;
                    w_div_nxt = w_dv_abs;
                    if (w_div_zero) begin
                        // Final values stored directly; sign fix-up disabled.
                        w_quo_nxt   = '1;
                        w_rem_nxt   = i_dividend;
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (w_ovf) begin
                        w_quo_nxt   = c_MIN_NEG;
                        w_rem_nxt   = '0;
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_quo_nxt   = w_dd_abs;
                        w_rem_nxt   = '0;
                        w_neg_q_nxt = w_dd_neg ^ w_dv_neg;
                        w_neg_r_nxt = w_dd_neg;
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    w_unpause   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pause   = 1'b1;
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_unpause   = 1'b1;
                w_valid     = ~i_flush;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sign-corrected result, computed from the values entering DONE so that
    // the output register is already loaded while result_valid is high.
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_res_fin;

    assign w_q_fin   = w_neg_q_nxt ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fin   = w_neg_r_nxt ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_res_fin = w_op_nxt[1] ? w_r_fin : w_q_fin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_rd    <= w_rd_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_div   <= w_div_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            if (w_state_nxt == S_DONE) begin
                r_result <= w_res_fin;
                r_rd_out <= w_rd_nxt;
            end
        end
    end

    // Pause is gated by reset so a start seen during reset cannot stall.
    assign o_pause_signal   = w_pause & rst;
    assign o_unpause_signal = w_unpause;
    assign o_result_valid   = w_valid;
    assign o_result         = r_result;
    assign o_rd_out         = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking testbench for div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [4:0]  i_rd_in;
    logic        i_flush;
    logic        o_pause_signal;
    logic        o_unpause_signal;
    logic [31:0] o_result;
    logic        o_result_valid;
    logic [4:0]  o_rd_out;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_op             (i_op),
        .i_dividend       (i_dividend),
        .i_divisor        (i_divisor),
        .i_rd_in          (i_rd_in),
        .i_flush          (i_flush),
        .o_pause_signal   (o_pause_signal),
        .o_unpause_signal (o_unpause_signal),
        .o_result         (o_result),
        .o_result_valid   (o_result_valid),
        .o_rd_out         (o_rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for result_valid. Returns what was seen.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic pause_iss, output int lat,
                         output int pause_cyc, output logic [31:0] res, output logic [4:0] rdo,
                         output logic unp, output logic pse);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_dividend = a; i_divisor = b; i_rd_in = rd;
        #1 pause_iss = o_pause_signal;
        lat = -1; pause_cyc = 0; res = '0; rdo = '0; unp = 1'b0; pse = 1'b1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            #1;
            if (o_result_valid) begin
                lat = k; res = o_result; rdo = o_rd_out;
                unp = o_unpause_signal; pse = o_pause_signal;
            end else if (o_pause_signal) begin
                pause_cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd9; i_divisor = 32'd3;
        i_rd_in = 5'd7; i_flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (o_pause_signal !== 1'b0 || o_unpause_signal !== 1'b0 || o_result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: pause=%b unpause=%b valid=%b, required all 0",
                     o_pause_signal, o_unpause_signal, o_result_valid);
        end
        n_checks++;
        if (o_result !== 32'd0 || o_rd_out !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_data: result=%h rd=%0d, required 0/0", o_result, o_rd_out);
        end
        i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo;
        do_op(2'b01, 32'd100, 32'd7, 5'd9, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (pi !== 1'b1) begin n_errors++; $display("FAIL divu_issue_pause: got %b want 1", pi); end
        n_checks++;
        if (lat !== 33) begin n_errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_checks++;
        if (res !== 32'd14) begin n_errors++; $display("FAIL divu_result: got %h want %h", res, 32'd14); end
        n_checks++;
        if (rdo !== 5'd9) begin n_errors++; $display("FAIL divu_rd: got %0d want 9", rdo); end
        n_checks++;
        if (unp !== 1'b1 || pse !== 1'b0) begin
            n_errors++; $display("FAIL divu_done_ctrl: unpause=%b pause=%b want 1/0", unp, pse);
        end
        n_checks++;
        if (pc !== 32) begin n_errors++; $display("FAIL divu_calc_pause: got %0d cycles want 32", pc); end
    endtask

    task automatic test_signed;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 33 || res !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL rem_neg: got %h lat %0d want ffffffff lat 33", res, lat);
        end
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 33 || res !== 32'hFFFF_FFFD) begin
            n_errors++; $display("FAIL div_neg: got %h lat %0d want fffffffd lat 33", res, lat);
        end
        do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd5, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (res !== 32'hFFFF_FFF2) begin
            n_errors++; $display("FAIL div_negdivisor: got %h want fffffff2", res);
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd6, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (res !== 32'd1) begin n_errors++; $display("FAIL divu_bigdiv: got %h want 1", res); end
        do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 5'd6, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (res !== 32'h7FFF_FFFE) begin n_errors++; $display("FAIL remu_bigdiv: got %h want 7ffffffe", res); end
    endtask

    task automatic test_div_zero;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo;
        do_op(2'b00, 32'd5, 32'd0, 5'd10, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 1 || res !== 32'hFFFF_FFFF || rdo !== 5'd10) begin
            n_errors++; $display("FAIL div_by0: got %h lat %0d rd %0d want ffffffff lat 1 rd 10", res, lat, rdo);
        end
        n_checks++;
        if (pi !== 1'b1 || unp !== 1'b1) begin
            n_errors++; $display("FAIL div_by0_ctrl: pause_issue=%b unpause=%b want 1/1", pi, unp);
        end
        do_op(2'b11, 32'd5, 32'd0, 5'd11, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 1 || res !== 32'd5) begin
            n_errors++; $display("FAIL remu_by0: got %h lat %0d want 5 lat 1", res, lat);
        end
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd12, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 1 || res !== 32'hFFFF_FFF9) begin
            n_errors++; $display("FAIL rem_by0_neg: got %h lat %0d want fffffff9 lat 1", res, lat);
        end
    endtask

    task automatic test_overflow;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo;
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 1 || res !== 32'h8000_0000) begin
            n_errors++; $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 1", res, lat);
        end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 1 || res !== 32'd0) begin
            n_errors++; $display("FAIL rem_ovf: got %h lat %0d want 0 lat 1", res, lat);
        end
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 33 || res !== 32'd0) begin
            n_errors++; $display("FAIL divu_noovf: got %h lat %0d want 0 lat 33", res, lat);
        end
    endtask

    task automatic test_flush;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo; int nv;
        do_op(2'b01, 32'd100, 32'd7, 5'd9, pi, lat, pc, res, rdo, unp, pse);
        @(negedge clk);
        i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd3; i_rd_in = 5'd17;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        i_flush = 1'b1;
        #1;
        n_checks++;
        if (o_unpause_signal !== 1'b1 || o_pause_signal !== 1'b0 || o_result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_calc: unpause=%b pause=%b valid=%b want 1/0/0",
                     o_unpause_signal, o_pause_signal, o_result_valid);
        end
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        n_checks++;
        if (o_unpause_signal !== 1'b0 || o_pause_signal !== 1'b0) begin
            n_errors++; $display("FAIL flush_idle: unpause=%b pause=%b want 0/0", o_unpause_signal, o_pause_signal);
        end
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (o_result_valid) nv++;
        end
        n_checks++;
        if (nv !== 0 || o_result !== 32'd14 || o_rd_out !== 5'd9) begin
            n_errors++; $display("FAIL flush_hold: valids=%0d result=%h rd=%0d want 0/0000000e/9", nv, o_result, o_rd_out);
        end
        // flush together with start in IDLE: nothing happens
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_dividend = 32'd50; i_divisor = 32'd5;
        #1;
        n_checks++;
        if (o_pause_signal !== 1'b0) begin
            n_errors++; $display("FAIL flush_start_pause: got %b want 0", o_pause_signal);
        end
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            i_start = 1'b0; i_flush = 1'b0;
            #1;
            if (o_result_valid || o_pause_signal || o_unpause_signal) nv++;
        end
        n_checks++;
        if (nv !== 0) begin n_errors++; $display("FAIL flush_start_quiet: active cycles=%0d want 0", nv); end
    endtask

    task automatic test_reset_mid;
        int nv;
        @(negedge clk);
        i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd3; i_rd_in = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_pause_signal !== 1'b0 || o_unpause_signal !== 1'b0 || o_result_valid !== 1'b0 ||
            o_result !== 32'd0 || o_rd_out !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_mid: pause=%b unpause=%b valid=%b result=%h rd=%0d want all 0",
                     o_pause_signal, o_unpause_signal, o_result_valid, o_result, o_rd_out);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (o_result_valid || o_pause_signal) nv++;
        end
        n_checks++;
        if (nv !== 0) begin n_errors++; $display("FAIL reset_mid_quiet: active cycles=%0d want 0", nv); end
    endtask

    task automatic test_back_to_back;
        logic pi, unp, pse; int lat, pc; logic [31:0] res; logic [4:0] rdo; int nv;
        do_op(2'b01, 32'd1000, 32'd3, 5'd1, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 33 || res !== 32'd333 || rdo !== 5'd1) begin
            n_errors++; $display("FAIL b2b_0: got %h lat %0d rd %0d want 0000014d lat 33 rd 1", res, lat, rdo);
        end
        do_op(2'b01, 32'd81, 32'd9, 5'd2, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (pi !== 1'b1 || lat !== 33 || res !== 32'd9 || rdo !== 5'd2) begin
            n_errors++; $display("FAIL b2b_1: got %h lat %0d rd %0d pause %b want 9 lat 33 rd 2 pause 1", res, lat, rdo, pi);
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd3, pi, lat, pc, res, rdo, unp, pse);
        n_checks++;
        if (lat !== 33 || res !== 32'hFFFF_FFFF || rdo !== 5'd3) begin
            n_errors++; $display("FAIL b2b_2: got %h lat %0d rd %0d want ffffffff lat 33 rd 3", res, lat, rdo);
        end
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (o_result_valid) nv++;
        end
        n_checks++;
        if (nv !== 0) begin n_errors++; $display("FAIL b2b_dup_valid: extra valids=%0d want 0", nv); end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_signed;
        test_div_zero;
        test_overflow;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
